uart_reg_stream_bridge: RTL and testbench

Adapter between byte streams (valid/ready) and the 16550-style 3-bit register bus of the UART master IP. It sits directly upstream of the IP, in the same position a fixed-message driver would occupy. After reset it programs the baud divisor and 8N1 framing. It then polls LSR, draining RBR into an rx stream and feeding tx-stream bytes into THR when the transmitter reports empty. Application logic sees plain byte streams and never touches UART registers.

---
 rtl/uart_reg_stream_bridge.sv | 219 +++++++++++++++++++++
 tb/tb_uart_reg_stream_bridge.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_stream_bridge.sv
// uart_reg_stream_bridge
// Bridges tx/rx byte streams (valid/ready) onto the 16550-style 3-bit
// register bus of the UART master IP. After reset it programs the baud
// divisor, 8N1 framing and FIFO control. It then polls LSR, drains RBR into
// a one-entry rx holding register and feeds tx bytes into THR when the
// transmitter is empty.
// Optional build macro: UART_BRIDGE_ERR_CNT_EN enables the saturating LSR
// error counter on err_count. When it is undefined, err_count is tied to zero.
// All bus outputs are registered, so every strobe appears one cycle after
// the state that requests it.

module uart_reg_stream_bridge #(
    parameter logic [15:0] DIVISOR    = 16'd27,
    parameter int unsigned RD_LATENCY = 1,
    parameter logic [7:0]  LCR_VAL    = 8'h03
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        init_done,
    output logic        o_tx_en,
    output logic [2:0]  o_waddr,
    output logic [7:0]  o_wdata,
    output logic        o_rx_en,
    output logic [2:0]  o_raddr,
    input  logic [7:0]  i_rdata,
    output logic [15:0] err_count
);

    localparam logic [1:0] LAT = RD_LATENCY[1:0];

    typedef enum logic [3:0] {
        INIT0,
        INIT1,
        INIT2,
        INIT3,
        INIT4,
        POLL_REQ,
        POLL_WAIT,
        RBR_REQ,
        RBR_WAIT,
        THR_WR
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] lat_cnt, lat_cnt_nxt;
    // 1: rx path wins when both paths are eligible
    logic       prio_rx, prio_rx_nxt;

    logic       tx_en_nxt;
    logic       rx_en_nxt;
    logic [2:0] waddr_nxt;
    logic [7:0] wdata_nxt;
    logic [2:0] raddr_nxt;
    logic       tx_ready_nxt;
    logic       init_done_nxt;
    logic       rx_load;
    logic       rd_ok;
    logic       wr_ok;

    // Next-state, next-output and path decision logic
    always_comb begin
        state_nxt     = state;
        lat_cnt_nxt   = lat_cnt;
        prio_rx_nxt   = prio_rx;
        tx_en_nxt     = 1'b0;
        rx_en_nxt     = 1'b0;
        waddr_nxt     = o_waddr;
        wdata_nxt     = o_wdata;
        raddr_nxt     = o_raddr;
        tx_ready_nxt  = 1'b0;
        init_done_nxt = init_done;
        rx_load       = 1'b0;
        rd_ok         = i_rdata[0] & ~rx_valid;
        wr_ok         = i_rdata[5] & tx_valid;
        case (state)
            INIT0: begin
                tx_en_nxt = 1'b1;
                waddr_nxt = 3'd3;
                wdata_nxt = 8'h80;
                state_nxt = INIT1;
            end
            INIT1: begin
                tx_en_nxt = 1'b1;
                waddr_nxt = 3'd0;
                wdata_nxt = DIVISOR[7:0];
                state_nxt = INIT2;
            end
            INIT2: begin
                tx_en_nxt = 1'b1;
                waddr_nxt = 3'd1;
                wdata_nxt = DIVISOR[15:8];
                state_nxt = INIT3;
            end
            INIT3: begin
                tx_en_nxt = 1'b1;
                waddr_nxt = 3'd3;
                wdata_nxt = LCR_VAL;
                state_nxt = INIT4;
            end
            INIT4: begin
                tx_en_nxt = 1'b1;
                waddr_nxt = 3'd2;
                wdata_nxt = 8'h07;
                state_nxt = POLL_REQ;
            end
            POLL_REQ: begin
                init_done_nxt = 1'b1;
                rx_en_nxt     = 1'b1;
                raddr_nxt     = 3'd5;
                lat_cnt_nxt   = '0;
                state_nxt     = POLL_WAIT;
            end
            POLL_WAIT: begin
                if (lat_cnt == LAT) begin
                    if (rd_ok && (!wr_ok || prio_rx)) begin
                        prio_rx_nxt = ~prio_rx;
                        state_nxt   = RBR_REQ;
                    end else if (wr_ok) begin
                        prio_rx_nxt = ~prio_rx;
                        state_nxt   = THR_WR;
                    end else begin
                        state_nxt   = POLL_REQ;
                    end
                end else begin
                    lat_cnt_nxt = lat_cnt + 2'd1;
                end
            end
            RBR_REQ: begin
                rx_en_nxt   = 1'b1;
                raddr_nxt   = 3'd0;
                lat_cnt_nxt = '0;
                state_nxt   = RBR_WAIT;
            end
            RBR_WAIT: begin
                if (lat_cnt == LAT) begin
                    rx_load   = 1'b1;
                    state_nxt = POLL_REQ;
                end else begin
                    lat_cnt_nxt = lat_cnt + 2'd1;
                end
            end
            THR_WR: begin
                tx_en_nxt    = 1'b1;
                tx_ready_nxt = 1'b1;
                waddr_nxt    = 3'd0;
                wdata_nxt    = tx_data;
                state_nxt    = POLL_REQ;
            end
            default: state_nxt = INIT0;
        endcase
    end

    // State register and registered bus/stream outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT0;
            lat_cnt   <= '0;
            prio_rx   <= 1'b1;
            o_tx_en   <= 1'b0;
            o_rx_en   <= 1'b0;
            o_waddr   <= '0;
            o_wdata   <= '0;
            o_raddr   <= '0;
            tx_ready  <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            lat_cnt   <= lat_cnt_nxt;
            prio_rx   <= prio_rx_nxt;
            o_tx_en   <= tx_en_nxt;
            o_rx_en   <= rx_en_nxt;
            o_waddr   <= waddr_nxt;
            o_wdata   <= wdata_nxt;
            o_raddr   <= raddr_nxt;
            tx_ready  <= tx_ready_nxt;
            init_done <= init_done_nxt;
        end
    end

    // One-entry rx holding register: filled by RBR sample, emptied by take
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else if (rx_load) begin
            rx_data  <= i_rdata;
            rx_valid <= 1'b1;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

`ifdef UART_BRIDGE_ERR_CNT_EN
    logic [15:0] err_cnt_q;
    logic        lsr_sample;

    assign lsr_sample = (state == POLL_WAIT) && (lat_cnt == LAT);

    // Saturating count of LSR samples flagging OE, PE or FE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (lsr_sample && (|i_rdata[3:1]) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_uart_reg_stream_bridge.sv
// tb_uart_reg_stream_bridge
// Drives the bridge with a behavioural UART register model and randomized
// stream traffic. A transaction-level reference model (holding register
// occupancy, priority toggle, error tally) predicts every bus strobe,
// stream handshake and counter value.

module tb_uart_reg_stream_bridge;

    localparam logic [15:0] DIV = 16'h01B2;
    localparam int unsigned LAT = 3;
    localparam logic [7:0]  LCR = 8'h03;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        init_done;
    logic        o_tx_en;
    logic [2:0]  o_waddr;
    logic [7:0]  o_wdata;
    logic        o_rx_en;
    logic [2:0]  o_raddr;
    logic [7:0]  i_rdata = '0;
    logic [15:0] err_count;

    always #5 clk = ~clk;

    uart_reg_stream_bridge #(
        .DIVISOR    (DIV),
        .RD_LATENCY (LAT),
        .LCR_VAL    (LCR)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .init_done (init_done),
        .o_tx_en   (o_tx_en),
        .o_waddr   (o_waddr),
        .o_wdata   (o_wdata),
        .o_rx_en   (o_rx_en),
        .o_raddr   (o_raddr),
        .i_rdata   (i_rdata),
        .err_count (err_count)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // reference model state
    bit          m_rx_full;
    logic [7:0]  m_rx_byte;
    bit          m_rx_load;
    logic [7:0]  m_rx_pend;
    bit          m_tx_acc;
    bit          m_prio_rx;
    logic [15:0] m_err;

    // stimulus knobs
    int          lsr_fixed = -1;
    int unsigned p_txv = 0;
    int unsigned p_rxr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ctl", 32'({init_done, tx_ready, rx_valid, o_tx_en, o_rx_en, o_waddr, o_raddr}), 32'd0);
        chk("rst_data", {rx_data, o_wdata, err_count}, 32'd0);
    endtask

    // advance one clock: apply edge effects to the model, then re-drive inputs
    task automatic tick();
        bit take_rx;
        bit take_tx;
        take_rx = m_rx_full && rx_ready;
        take_tx = m_tx_acc;
        @(negedge clk);
        m_tx_acc = 1'b0;
        i_rdata  = 8'($urandom);
        if (take_rx) m_rx_full = 1'b0;
        if (m_rx_load) begin
            m_rx_full = 1'b1;
            m_rx_byte = m_rx_pend;
            m_rx_load = 1'b0;
        end
        if (take_tx) tx_valid = 1'b0;
        if (!tx_valid && ($urandom_range(99) < p_txv)) begin
            tx_valid = 1'b1;
            tx_data  = 8'($urandom);
        end
        rx_ready = ($urandom_range(99) < p_rxr);
        chk("rx_valid", 32'(rx_valid), 32'(m_rx_full));
        if (m_rx_full) chk("rx_data", 32'(rx_data), 32'(m_rx_byte));
    endtask

    task automatic expect_idle();
        chk("idle_strobes", 32'({o_tx_en, o_rx_en, tx_ready}), 32'd0);
    endtask

    task automatic expect_read(input logic [2:0] addr);
        chk("rd_strobe", 32'({o_tx_en, o_rx_en, tx_ready}), 32'b010);
        chk("raddr", 32'(o_raddr), 32'(addr));
    endtask

    task automatic expect_write(input logic [2:0] addr, input logic [7:0] data, input bit txr);
        chk("wr_strobe", 32'({o_tx_en, o_rx_en, tx_ready}), 32'({2'b10, txr}));
        chk("waddr", 32'(o_waddr), 32'(addr));
        chk("wdata", 32'(o_wdata), 32'(data));
    endtask

    // IP register model: read data is valid only in the sample cycle
    task automatic wait_sample(input logic [2:0] addr, input logic [7:0] value);
        for (int unsigned j = 1; j <= LAT; j++) begin
            tick();
            expect_idle();
            chk("raddr_hold", 32'(o_raddr), 32'(addr));
            if (j == LAT) i_rdata = value;
        end
    endtask

    task automatic reset_and_init();
        logic [2:0] ia [5];
        logic [7:0] id [5];
        ia = '{3'd3, 3'd0, 3'd1, 3'd3, 3'd2};
        id = '{8'h80, DIV[7:0], DIV[15:8], LCR, 8'h07};
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        #1;
        chk_reset_outputs();
        repeat (2) @(negedge clk);
        chk_reset_outputs();
        m_rx_full = 1'b0;
        m_rx_load = 1'b0;
        m_tx_acc  = 1'b0;
        m_prio_rx = 1'b1;
        m_err     = '0;
        #2 rst_n = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            @(negedge clk);
            expect_write(ia[i], id[i], 1'b0);
            chk("init_done_low", 32'(init_done), 32'd0);
        end
        @(negedge clk);
        chk("init_done_high", 32'(init_done), 32'd1);
    endtask

    // one LSR poll plus whatever service it triggers; ends at the next poll strobe
    task automatic poll_once(input bit abort_in_rbr, output int unsigned kind);
        logic [7:0] lsr;
        logic [7:0] rbr;
        bit rd_ok;
        bit wr_ok;
        expect_read(3'd5);
        lsr = (lsr_fixed >= 0) ? 8'(lsr_fixed) : 8'($urandom);
        wait_sample(3'd5, lsr);
        rd_ok = lsr[0] && !m_rx_full;
        wr_ok = lsr[5] && tx_valid;
        if (rd_ok && (!wr_ok || m_prio_rx)) kind = 1;
        else if (wr_ok) kind = 2;
        else kind = 0;
        if (kind != 0) m_prio_rx = !m_prio_rx;
        if ((|lsr[3:1]) && (m_err != 16'hFFFF)) m_err = m_err + 16'd1;
        tick();
        expect_idle();
`ifdef UART_BRIDGE_ERR_CNT_EN
        chk("err_count", 32'(err_count), 32'(m_err));
`else
        chk("err_count", 32'(err_count), 32'd0);
`endif
        tick();
        if (kind == 1) begin
            expect_read(3'd0);
            if (abort_in_rbr) begin
                tick();
                expect_idle();
                #2 rst_n = 1'b0;
                #1;
                chk_reset_outputs();
                return;
            end
            rbr = 8'($urandom);
            wait_sample(3'd0, rbr);
            m_rx_load = 1'b1;
            m_rx_pend = rbr;
            tick();
            expect_idle();
            tick();
        end else if (kind == 2) begin
            expect_write(3'd0, tx_data, 1'b1);
            m_tx_acc = 1'b1;
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: sim time %0t reached, required finish earlier", $time);
        $fatal(1);
    end

    initial begin
        int unsigned kind;
        #1;
        reset_and_init();

        // both paths eligible: service alternates rx, tx, rx, tx
        lsr_fixed = 8'h21; p_txv = 100; p_rxr = 100;
        repeat (4) poll_once(1'b0, kind);

        // consumer stalled with DR stuck high: one RBR read, then polls only
        lsr_fixed = 8'h01; p_txv = 0; p_rxr = 0;
        repeat (6) poll_once(1'b0, kind);
        p_rxr = 100;
        repeat (3) poll_once(1'b0, kind);

        // transmit only
        lsr_fixed = 8'h20; p_txv = 100; p_rxr = 100;
        repeat (4) poll_once(1'b0, kind);

        // fully random LSR and stream traffic
        lsr_fixed = -1; p_txv = 50; p_rxr = 50;
        repeat (150) poll_once(1'b0, kind);

        // error flags on fresh counter, then reset during RBR wait
        reset_and_init();
        lsr_fixed = 8'h0A; p_txv = 0; p_rxr = 100;
        repeat (3) poll_once(1'b0, kind);
        lsr_fixed = 8'h01;
        poll_once(1'b1, kind);
        reset_and_init();
        lsr_fixed = -1; p_txv = 60; p_rxr = 70;
        repeat (30) poll_once(1'b0, kind);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
